sdram_access_arbiter: RTL and testbench
=======================================

Name: sdram_access_arbiter

Overview:
- Shares the single SDRAM base controller between two requesters: a write channel (photon-count capture) and a read channel (host readback).
- Sequences one access at a time into the base controller's call/done interface. The base interface is a 2-bit call, a 2-bit done, a 24-bit address, and 16-bit write/read data.
- Applies write priority with a starvation guard for reads, plus a per-access watchdog timeout.

Parameters:
- TIMEOUT_CYC, 1024, cycles allowed between call assertion and done before the access is aborted.
- TMO_W, 11, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYC.
- MAX_WR_STREAK, 8, consecutive write grants allowed while a read is pending.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  1  write request; held high until wr_ack
- wr_addr  in  24  write address; sampled at grant
- wr_data  in  16  write data; sampled at grant
- wr_ack  out  1  one-cycle pulse: write completed
- rd_req  in  1  read request; held high until rd_ack
- rd_addr  in  24  read address; sampled at grant
- rd_data  out  16  read data; valid in the rd_ack cycle and held until the next read completes
- rd_ack  out  1  one-cycle pulse: read completed
- sd_call  out  2  to base controller; [1]=write, [0]=read; at most one bit set
- sd_addr  out  24  to base controller address
- sd_wdata  out  16  to base controller write data
- sd_done  in  2  from base controller; [1]=write done, [0]=read done
- sd_rdata  in  16  from base controller read data
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky flag: an access was aborted
- err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0:
  - All outputs are 0: sd_call=2'b00, sd_addr=0, sd_wdata=0, wr_ack=0, rd_ack=0, rd_data=0, busy=0, timeout_err=0.
  - State=IDLE, wr_streak=0, timeout counter=0.
  - Reset asserted mid-access drops sd_call immediately and issues no ack.
- All outputs are registered.
- States: IDLE, WR, RD, GAP.
- IDLE, arbitration evaluated each cycle:
  - Grant write if wr_req && (!rd_req || wr_streak < MAX_WR_STREAK).
  - Otherwise grant read if rd_req.
  - On a grant, on the same edge: latch the address (and wr_data for writes) into sd_addr/sd_wdata, set the matching sd_call bit, clear the timeout counter, and enter WR or RD.
  - Latency: req high at edge k gives sd_call high after edge k.
- WR / RD:
  - sd_call is held constant and the timeout counter increments each cycle.
  - Completion: the matching done bit (sd_done[1] in WR, sd_done[0] in RD) sampled high at edge d. On that edge:
    - sd_call=0.
    - Pulse the matching ack for one cycle.
    - In RD, rd_data<=sd_rdata.
    - Enter GAP.
  - The non-matching done bit is ignored.
  - Timeout: counter reaches TIMEOUT_CYC-1 without the matching done. Then:
    - sd_call=0, timeout_err<=1, no ack, enter GAP.
    - The requester, still holding req, is re-arbitrated.
  - Done and timeout on the same edge: done wins, normal completion, timeout_err unchanged.
- GAP: exactly one cycle with sd_call=0, then IDLE. Earliest next grant is 2 edges after done.
- wr_streak:
  - +1 on each write completion, saturating at MAX_WR_STREAK.
  - Cleared to 0 on each read completion.
  - Unchanged on timeout.
- A requester that drops req after grant does not cancel the access; the ack still pulses.
- Changes to addr/data after grant have no effect.
- err_clr=1 clears timeout_err on the next edge. If a timeout occurs on the same edge, set wins.
- sd_call is never 2'b11. sd_call bits are never set in IDLE or GAP.

Test Plan:
- Single write:
  - Stimulus: wr_req with wr_addr=24'h000123, wr_data=16'hA5A5; sd_done[1] pulsed 5 cycles after sd_call rises.
  - Response: sd_call=2'b10 from the cycle after req, sd_addr=24'h000123, sd_wdata=16'hA5A5; a single wr_ack pulse the cycle after done; sd_call low in the same cycle; busy low 2 cycles after done.
- Single read:
  - Stimulus: rd_req with rd_addr=24'hFFFFFF; sd_done[0] with sd_rdata=16'h1234.
  - Response: sd_call=2'b01; rd_ack pulse with rd_data=16'h1234, held afterwards.
- Contention:
  - Stimulus: wr_req and rd_req both held high continuously, every access done in 3 cycles, MAX_WR_STREAK=8.
  - Response: grant order is 8 writes, 1 read, repeating.
  - Also: rd_req alone always granted; wr_streak resets after the read.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, done never returned.
  - Response: sd_call drops after 16 call cycles; timeout_err=1; no ack; GAP, then the same request is re-granted; err_clr pulse gives timeout_err=0.
- Edge cases:
  - Done on the exact timeout edge gives an ack and timeout_err stays 0.
  - sd_done[0] during WR is ignored and sd_call stays 2'b10.
  - err_clr coincident with a timeout leaves timeout_err=1.
- Reset mid-write: rst_n low 2 cycles into WR gives all outputs 0 asynchronously, no wr_ack, and IDLE after release.

Source files
------------

// File: rtl/sdram_access_arbiter.sv
// Arbiter sharing one SDRAM base controller between a write (capture) channel and a read
// (host readback) channel. One access at a time, write priority with a read starvation guard,
// and a per-access watchdog that aborts an access whose done never arrives.
module sdram_access_arbiter #(
  parameter int unsigned TIMEOUT_CYC   = 1024,
  parameter int unsigned TMO_W         = 11,
  parameter int unsigned MAX_WR_STREAK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [23:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [23:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  output logic [1:0]  sd_call,
  output logic [23:0] sd_addr,
  output logic [15:0] sd_wdata,
  input  logic [1:0]  sd_done,
  input  logic [15:0] sd_rdata,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int unsigned STREAK_W = $clog2(MAX_WR_STREAK + 1);
  localparam logic [TMO_W-1:0]    TmoLast   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(MAX_WR_STREAK);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StGap} state_e;

  state_e              state;
  logic [TMO_W-1:0]    tmoCnt;
  logic [STREAK_W-1:0] wrStreak;

  logic grantWr;
  logic grantRd;
  logic doneHit;
  logic tmoHit;

  // Arbitration and completion decode; a pending read caps the run of back-to-back writes.
  always_comb begin
    grantWr = wr_req && (!rd_req || (wrStreak < StreakMax));
    grantRd = !grantWr && rd_req;
    doneHit = ((state == StWr) && sd_done[1]) || ((state == StRd) && sd_done[0]);
    tmoHit  = (tmoCnt == TmoLast);
  end

  // Access sequencer with registered outputs; done takes precedence over the watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      tmoCnt      <= '0;
      wrStreak    <= '0;
      sd_call     <= 2'b00;
      sd_addr     <= '0;
      sd_wdata    <= '0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      rd_data     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      // A timeout on this same edge overrides the clear below.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        StIdle: begin
          if (grantWr) begin
            sd_addr  <= wr_addr;
            sd_wdata <= wr_data;
            sd_call  <= 2'b10;
            tmoCnt   <= '0;
            busy     <= 1'b1;
            state    <= StWr;
          end else if (grantRd) begin
            sd_addr  <= rd_addr;
            sd_call  <= 2'b01;
            tmoCnt   <= '0;
            busy     <= 1'b1;
            state    <= StRd;
          end
        end
        StWr, StRd: begin
          if (doneHit) begin
            sd_call <= 2'b00;
            state   <= StGap;
            if (state == StWr) begin
              wr_ack <= 1'b1;
              if (wrStreak < StreakMax) begin
                wrStreak <= wrStreak + 1'b1;
              end
            end else begin
              rd_ack   <= 1'b1;
              rd_data  <= sd_rdata;
              wrStreak <= '0;
            end
          end else if (tmoHit) begin
            // Abort without ack; the requester still holds req and is arbitrated again.
            sd_call     <= 2'b00;
            timeout_err <= 1'b1;
            state       <= StGap;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end
        StGap: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Self-checking bench for sdram_access_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model of the arbitration rules.
module tb_sdram_access_arbiter;

  localparam int TMO  = 16;
  localparam int MAXS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req, err_clr;
  logic [23:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_ack, rd_ack;
  logic [15:0] rd_data;
  logic [1:0]  sd_call;
  logic [23:0] sd_addr;
  logic [15:0] sd_wdata;
  logic [1:0]  sd_done;
  logic [15:0] sd_rdata;
  logic        busy, timeout_err;

  int          nTests = 0;
  int          nFail  = 0;
  int          mStreak;
  bit          mErr;
  logic [15:0] mRdData;
  bit          noise;
  bit          clrAtTmo;
  bit          grantLog[$];

  sdram_access_arbiter #(
    .TIMEOUT_CYC  (TMO),
    .TMO_W        (5),
    .MAX_WR_STREAK(MAXS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ack     (rd_ack),
    .sd_call    (sd_call),
    .sd_addr    (sd_addr),
    .sd_wdata   (sd_wdata),
    .sd_done    (sd_done),
    .sd_rdata   (sd_rdata),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] eCall, input logic eWrAck,
                         input logic eRdAck, input logic eBusy);
    chk({tag, ".call"}, {30'd0, sd_call}, {30'd0, eCall});
    chk({tag, ".wr_ack"}, {31'd0, wr_ack}, {31'd0, eWrAck});
    chk({tag, ".rd_ack"}, {31'd0, rd_ack}, {31'd0, eRdAck});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eBusy});
    chk({tag, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, mErr});
    chk({tag, ".rd_data"}, {16'd0, rd_data}, {16'd0, mRdData});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".call"}, {30'd0, sd_call}, 32'd0);
    chk({tag, ".addr"}, {8'd0, sd_addr}, 32'd0);
    chk({tag, ".wdata"}, {16'd0, sd_wdata}, 32'd0);
    chk({tag, ".acks"}, {30'd0, wr_ack, rd_ack}, 32'd0);
    chk({tag, ".rd_data"}, {16'd0, rd_data}, 32'd0);
    chk({tag, ".busy_err"}, {30'd0, busy, timeout_err}, 32'd0);
  endtask

  // One arbitration cycle from IDLE: predict the grant, play the base controller with done
  // arriving 'lat' cycles after the call (lat > TMO means never), then step through GAP.
  task automatic run_access(input int lat, input bit keep, input logic [15:0] rdVal);
    bit          isWr;
    logic [23:0] gAddr;
    logic [15:0] gData;
    logic [1:0]  d;
    logic        clr;
    int          endI;
    isWr  = wr_req && (!rd_req || mStreak < MAXS);
    gAddr = isWr ? wr_addr : rd_addr;
    gData = wr_data;
    step();
    chk_out("grant", isWr ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b1);
    chk("grant.addr", {8'd0, sd_addr}, {8'd0, gAddr});
    if (isWr) chk("grant.wdata", {16'd0, sd_wdata}, {16'd0, gData});
    grantLog.push_back(isWr);
    endI = (lat < TMO) ? lat : TMO;
    for (int i = 1; i <= endI; i++) begin
      d = 2'b00;
      if (i == lat) d[isWr ? 1 : 0] = 1'b1;
      if ((i == 1 && lat > 1) || (noise && $urandom_range(0, 3) == 0)) d[isWr ? 0 : 1] = 1'b1;
      sd_done  = d;
      sd_rdata = (i == lat) ? rdVal : 16'($urandom);
      clr      = (noise && $urandom_range(0, 7) == 0) || (clrAtTmo && i == TMO);
      err_clr  = clr;
      if (i == 1) begin
        wr_addr = 24'($urandom);
        rd_addr = 24'($urandom);
        wr_data = 16'($urandom);
      end
      step();
      if (i == lat) begin
        if (clr) mErr = 1'b0;
        if (isWr) begin
          if (mStreak < MAXS) mStreak++;
        end else begin
          mStreak = 0;
          mRdData = rdVal;
        end
        chk_out("done", 2'b00, isWr, !isWr, 1'b1);
        if (isWr) wr_req = keep;
        else rd_req = keep;
      end else if (i == TMO) begin
        mErr = 1'b1;
        chk_out("tmo", 2'b00, 1'b0, 1'b0, 1'b1);
      end else begin
        if (clr) mErr = 1'b0;
        chk_out("run", isWr ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b1);
        chk("run.addr", {8'd0, sd_addr}, {8'd0, gAddr});
      end
    end
    sd_done = 2'b00;
    err_clr = 1'b0;
    step();
    chk_out("gap", 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; wr_req = 0; rd_req = 0; err_clr = 0;
    wr_addr = 0; rd_addr = 0; wr_data = 0; sd_done = 0; sd_rdata = 0;
    mStreak = 0; mErr = 0; mRdData = 0; noise = 0; clrAtTmo = 0;
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk_out("idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Single write, done 5 cycles after the call
    wr_addr = 24'h000123; wr_data = 16'hA5A5; wr_req = 1'b1;
    run_access(5, 1'b0, 16'h0);
    chk("single_wr.grant", {31'd0, grantLog[$]}, 32'd1);

    // Single read
    rd_addr = 24'hFFFFFF; rd_req = 1'b1;
    run_access(4, 1'b0, 16'h1234);
    chk("single_rd.grant", {31'd0, grantLog[$]}, 32'd0);
    step();
    step();
    chk("single_rd.held", {16'd0, rd_data}, 32'h1234);

    // Contention: both requests held, three-cycle accesses
    grantLog.delete();
    wr_req = 1'b1; rd_req = 1'b1;
    repeat (18) run_access(3, 1'b1, 16'($urandom));
    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("contention.order%0d", i), {31'd0, grantLog[i]}, {31'd0, (i % 9) != 8});
    end

    // Timeout, then the same write is granted again and completes
    wr_req = 1'b1;
    run_access(99, 1'b0, 16'h0);
    run_access(4, 1'b0, 16'h0);
    chk("tmo.regrant", {31'd0, grantLog[$]}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    mErr = 1'b0;
    chk("tmo.err_clr", {31'd0, timeout_err}, 32'd0);

    // Done exactly on the timeout edge
    wr_req = 1'b1;
    run_access(TMO, 1'b0, 16'h0);

    // err_clr on the timeout edge: set wins
    clrAtTmo = 1'b1;
    rd_req = 1'b1;
    run_access(99, 1'b0, 16'h0);
    clrAtTmo = 1'b0;
    run_access(2, 1'b0, 16'hBEEF);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    mErr = 1'b0;

    // Reset two cycles into a write
    wr_req = 1'b1;
    step();
    chk("rst_mid.grant", {30'd0, sd_call}, 32'd2);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_mid.async");
    wr_req = 1'b0;
    mStreak = 0; mErr = 0; mRdData = 0;
    step();
    step();
    chk_zero("rst_mid.held");
    rst_n = 1'b1;
    step();
    chk_out("rst_mid.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    noise = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (!wr_req && $urandom_range(0, 1) == 1) wr_req = 1'b1;
      if (!rd_req && $urandom_range(0, 1) == 1) rd_req = 1'b1;
      if (!wr_req && !rd_req) wr_req = 1'b1;
      run_access(int'($urandom_range(1, 20)), 1'b0, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
